// File: rtl/u409_ata_pio_sequencer_pkg.sv
// Shared definitions for the U409 ATA PIO sequencer: state encoding, default timings, counter width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package u409_ata_pkg;

  localparam int CNT_W = 8;

  // Default timings in CLK40 clocks (25 ns each).
  localparam int T1_PIO0_DEF       = 3;
  localparam int T2_PIO0_DEF       = 7;
  localparam int TREC_PIO0_DEF     = 13;
  localparam int T1_PIO4_DEF       = 1;
  localparam int T2_PIO4_DEF       = 3;
  localparam int TREC_PIO4_DEF     = 1;
  localparam int IORDY_TIMEOUT_DEF = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RECOVER
  } state_t;

  // Counter reload value for a state lasting 'clocks' clocks.
  // The state exits on the edge where the counter reads zero.
  function automatic logic [CNT_W-1:0] cnt_load(input int clocks);
    return CNT_W'(clocks - 1);
  endfunction

endpackage

// File: rtl/u409_ata_pio_sequencer_if.sv
// CPU-side request and ATA-side strobe signals of the PIO sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; BUSY and ATA_TACK tell the CPU side when a cycle is done.
// Ports: TSn/RnW/ATA_SPACE/ATA_SEC (decoded request), PPIO/SPIO (jumpers), IORDY (async ready),
//        IORn/IOWn/ATA_CYC/DLATCH (ATA bus), ATA_TACK/ATA_TIMEOUT/BUSY (status to transfer-ack logic).
interface u409_ata_pio_sequencer_if;

  logic TSn;
  logic RnW;
  logic ATA_SPACE;
  logic ATA_SEC;
  logic PPIO;
  logic SPIO;
  logic IORDY;

  logic IORn;
  logic IOWn;
  logic ATA_CYC;
  logic DLATCH;
  logic ATA_TACK;
  logic ATA_TIMEOUT;
  logic BUSY;

  modport master (
    output TSn, RnW, ATA_SPACE, ATA_SEC, PPIO, SPIO, IORDY,
    input  IORn, IOWn, ATA_CYC, DLATCH, ATA_TACK, ATA_TIMEOUT, BUSY
  );

  modport slave (
    input  TSn, RnW, ATA_SPACE, ATA_SEC, PPIO, SPIO, IORDY,
    output IORn, IOWn, ATA_CYC, DLATCH, ATA_TACK, ATA_TIMEOUT, BUSY
  );

endinterface

// File: rtl/u409_ata_pio_sequencer_sync2.sv
// Generic two-flop synchronizer for a single asynchronous input.
// Latency: 2 clocks from input change to q.
// Backpressure: none.
// Ports: clk, rst (sync, active-high), d (async input), q (synchronized output).
module u409_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/u409_ata_pio_sequencer.sv
// Turns a decoded ATA register hit into a timed PIO cycle with IORDY extension and a one-clock ack.
// Latency: start edge to ATA_TACK = T1 + T2 + IORDY extension clocks; BUSY until recovery ends.
// Backpressure: one-deep pending slot for a start seen while busy; further starts are dropped.
// Ports: CLK40, RESET (sync, active-high), bus (slave side: request in, ATA strobes and status out).
module u409_ata_pio_sequencer
  import u409_ata_pkg::*;
#(
  parameter int T1_PIO0       = T1_PIO0_DEF,
  parameter int T2_PIO0       = T2_PIO0_DEF,
  parameter int TREC_PIO0     = TREC_PIO0_DEF,
  parameter int T1_PIO4       = T1_PIO4_DEF,
  parameter int T2_PIO4       = T2_PIO4_DEF,
  parameter int TREC_PIO4     = TREC_PIO4_DEF,
  parameter int IORDY_TIMEOUT = IORDY_TIMEOUT_DEF
) (
  input logic                      CLK40,
  input logic                      RESET,
  u409_ata_pio_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] EXT_MAX = CNT_W'(IORDY_TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ext_q, ext_d;
  // Only direction and timing mode are kept per cycle; the channel select
  // itself is decoded into PCS/SCS outside this block.
  logic             rnw_q, rnw_d;
  logic             pio4_q, pio4_d;
  logic             tout_q, tout_d;
  logic             pend_q, pend_d;
  logic             pend_rnw_q, pend_rnw_d;
  logic             pend_pio4_q, pend_pio4_d;

  logic iorn_q, iorn_d, iown_q, iown_d, cyc_q, cyc_d;
  logic tack_q, tack_d, tmo_q, tmo_d, busy_q, busy_d;

  logic iordy_s;
  logic start, start_pio4;
  logic go_setup, go_rnw, go_pio4;

  u409_sync2 #(.RST_VAL(1'b1)) u_iordy_sync (
    .clk (CLK40),
    .rst (RESET),
    .d   (bus.IORDY),
    .q   (iordy_s)
  );

  assign start      = !bus.TSn && bus.ATA_SPACE;
  assign start_pio4 = bus.ATA_SEC ? bus.SPIO : bus.PPIO;

  // State register (outputs are registered alongside so they change right after the edge).
  always_ff @(posedge CLK40) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ext_q       <= '0;
      rnw_q       <= 1'b0;
      pio4_q      <= 1'b0;
      tout_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_rnw_q  <= 1'b0;
      pend_pio4_q <= 1'b0;
      iorn_q      <= 1'b1;
      iown_q      <= 1'b1;
      cyc_q       <= 1'b0;
      tack_q      <= 1'b0;
      tmo_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ext_q       <= ext_d;
      rnw_q       <= rnw_d;
      pio4_q      <= pio4_d;
      tout_q      <= tout_d;
      pend_q      <= pend_d;
      pend_rnw_q  <= pend_rnw_d;
      pend_pio4_q <= pend_pio4_d;
      iorn_q      <= iorn_d;
      iown_q      <= iown_d;
      cyc_q       <= cyc_d;
      tack_q      <= tack_d;
      tmo_q       <= tmo_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
    ext_d       = ext_q;
    rnw_d       = rnw_q;
    pio4_d      = pio4_q;
    tout_d      = tout_q;
    pend_d      = pend_q;
    pend_rnw_d  = pend_rnw_q;
    pend_pio4_d = pend_pio4_q;
    go_setup    = 1'b0;
    go_rnw      = bus.RnW;
    go_pio4     = start_pio4;

    if (state_q != ST_IDLE && start && !pend_q) begin
      pend_d      = 1'b1;
      pend_rnw_d  = bus.RnW;
      pend_pio4_d = start_pio4;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) go_setup = 1'b1;
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = cnt_load(pio4_q ? T2_PIO4 : T2_PIO0);
        end
      end
      ST_STROBE: begin
        // Counter parked at zero marks the last minimum clock and every extension clock.
        if (cnt_q == '0) begin
          if (iordy_s) begin
            state_d = ST_HOLD;
          end else if (ext_q == EXT_MAX) begin
            state_d = ST_HOLD;
            tout_d  = 1'b1;
          end else begin
            ext_d = ext_q + CNT_W'(1);
          end
        end
      end
      ST_HOLD: begin
        state_d = ST_RECOVER;
        cnt_d   = cnt_load(pio4_q ? TREC_PIO4 : TREC_PIO0);
      end
      ST_RECOVER: begin
        if (cnt_q == '0) begin
          if (pend_q) begin
            go_setup = 1'b1;
            go_rnw   = pend_rnw_q;
            go_pio4  = pend_pio4_q;
            pend_d   = 1'b0;
          end else if (start) begin
            // Start on the last recovery clock goes straight to SETUP rather than parking.
            go_setup = 1'b1;
            pend_d   = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (go_setup) begin
      state_d = ST_SETUP;
      rnw_d   = go_rnw;
      pio4_d  = go_pio4;
      cnt_d   = cnt_load(go_pio4 ? T1_PIO4 : T1_PIO0);
      ext_d   = '0;
      tout_d  = 1'b0;
    end
  end

  // Output logic, decoded from the next state so the registered outputs line up with it.
  always_comb begin
    iorn_d = !(state_d == ST_STROBE && rnw_d);
    iown_d = !(state_d == ST_STROBE && !rnw_d);
    cyc_d  = state_d inside {ST_SETUP, ST_STROBE, ST_HOLD};
    tack_d = (state_d == ST_HOLD);
    tmo_d  = (state_d == ST_HOLD) && tout_d;
    busy_d = (state_d != ST_IDLE);
  end

  assign bus.IORn        = iorn_q;
  assign bus.IOWn        = iown_q;
  assign bus.ATA_CYC     = cyc_q;
  assign bus.ATA_TACK    = tack_q;
  assign bus.ATA_TIMEOUT = tmo_q;
  assign bus.BUSY        = busy_q;

  // Whether this strobe clock is the last depends on the synchronized IORDY
  // sampled at the closing edge, so DLATCH is decoded straight from flops.
  assign bus.DLATCH = (state_q == ST_STROBE) && rnw_q && (cnt_q == '0) &&
                      (iordy_s || ext_q == EXT_MAX);

endmodule

// File: tb/tb_u409_ata_pio_sequencer.sv
module tb_u409_ata_pio_sequencer;

  logic CLK40 = 1'b0;
  logic RESET;
  always #12 CLK40 = ~CLK40;

  u409_ata_pio_sequencer_if bus();

  u409_ata_pio_sequencer dut (
    .CLK40 (CLK40),
    .RESET (RESET),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge CLK40) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int tack_cyc;
    int tmo;
    int slen;
    int rd;
    int dl_cyc;
  } exp_t;

  exp_t sbq[$];
  int   tack_total = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int tack_cyc, input int tmo, input int slen, input int rd, input int dl_cyc);
    exp_t e;
    e.tack_cyc = tack_cyc;
    e.tmo      = tmo;
    e.slen     = slen;
    e.rd       = rd;
    e.dl_cyc   = dl_cyc;
    sbq.push_back(e);
  endtask

  // Issue a one-clock start; e0 is the index of the edge that samples it.
  task automatic start(input logic rnw, input logic sec, output int e0);
    @(posedge CLK40); #1;
    bus.TSn       = 1'b0;
    bus.ATA_SPACE = 1'b1;
    bus.RnW       = rnw;
    bus.ATA_SEC   = sec;
    e0            = cyc + 1;
    @(posedge CLK40); #1;
    bus.TSn       = 1'b1;
    bus.ATA_SPACE = 1'b0;
  endtask

  // Return at the falling edge that follows rising edge n.
  task automatic at_neg(input int n);
    @(negedge CLK40);
    while (cyc < n) @(negedge CLK40);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge CLK40);
    while (bus.BUSY && n < 400) begin
      @(negedge CLK40);
      n++;
    end
    total++;
    if (bus.BUSY) begin
      bad++;
      $display("FAIL wait_idle: BUSY still 1 after %0d clocks, required 0", n);
    end
  endtask

  // Monitor: accumulates strobe/DLATCH activity and checks each ATA_TACK against the scoreboard.
  initial begin
    int   s_len, rd_seen, wr_seen, dl_cyc, dl_cnt;
    exp_t e;
    s_len = 0; rd_seen = 0; wr_seen = 0; dl_cyc = -1; dl_cnt = 0;
    forever begin
      @(negedge CLK40);
      if (RESET !== 1'b0) begin
        s_len = 0; rd_seen = 0; wr_seen = 0; dl_cyc = -1; dl_cnt = 0;
      end else begin
        if (!bus.IORn || !bus.IOWn) s_len++;
        if (!bus.IORn) rd_seen = 1;
        if (!bus.IOWn) wr_seen = 1;
        if (bus.DLATCH) begin
          dl_cyc = cyc;
          dl_cnt++;
        end
        if (bus.ATA_TIMEOUT && !bus.ATA_TACK) begin
          total++;
          bad++;
          $display("FAIL timeout_without_tack: ATA_TIMEOUT=1 ATA_TACK=0 at cyc %0d, required ATA_TACK=1", cyc);
        end
        if (bus.ATA_TACK) begin
          tack_total++;
          if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_tack: ATA_TACK at cyc %0d with no cycle outstanding", cyc);
          end else begin
            e = sbq.pop_front();
            chk("tack_cycle",  cyc, e.tack_cyc);
            chk("tack_timeout", int'(bus.ATA_TIMEOUT), e.tmo);
            chk("strobe_len",  s_len, e.slen);
            chk("strobe_dir",  rd_seen * 2 + wr_seen, e.rd ? 2 : 1);
            chk("dlatch_cnt",  dl_cnt, e.rd ? 1 : 0);
            if (e.rd != 0) chk("dlatch_cycle", dl_cyc, e.dl_cyc);
          end
          s_len = 0; rd_seen = 0; wr_seen = 0; dl_cyc = -1; dl_cnt = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, e1, snap;
    RESET         = 1'b1;
    bus.TSn       = 1'b1;
    bus.ATA_SPACE = 1'b0;
    bus.RnW       = 1'b1;
    bus.ATA_SEC   = 1'b0;
    bus.PPIO      = 1'b0;
    bus.SPIO      = 1'b1;
    bus.IORDY     = 1'b1;

    // Reset state: IORn, IOWn, ATA_CYC, DLATCH, ATA_TACK, ATA_TIMEOUT, BUSY.
    repeat (2) @(negedge CLK40);
    chk("reset_outputs",
        int'({bus.IORn, bus.IOWn, bus.ATA_CYC, bus.DLATCH, bus.ATA_TACK, bus.ATA_TIMEOUT, bus.BUSY}),
        int'(7'b1100000));
    @(posedge CLK40); #1;
    RESET = 1'b0;
    repeat (3) @(posedge CLK40);

    // PIO0 read, primary: strobe edges 3..10, TACK at 10, ATA_CYC off after 11, BUSY 24 clocks.
    start(1'b1, 1'b0, e0);
    push(e0 + 10, 0, 7, 1, e0 + 9);
    at_neg(e0 + 2);  chk("pio0_setup_iorn_high", int'(bus.IORn), 1);
    at_neg(e0 + 10); chk("pio0_cyc_in_hold", int'(bus.ATA_CYC), 1);
    at_neg(e0 + 11); chk("pio0_cyc_off_recover", int'(bus.ATA_CYC), 0);
    at_neg(e0 + 23); chk("pio0_busy_last", int'(bus.BUSY), 1);
    at_neg(e0 + 24); chk("pio0_idle", int'(bus.BUSY), 0);

    // PIO4 write, secondary: IOWn edges 1..4, TACK at 4, IDLE after 6.
    start(1'b0, 1'b1, e0);
    push(e0 + 4, 0, 3, 0, -1);
    at_neg(e0 + 5); chk("pio4_busy_last", int'(bus.BUSY), 1);
    at_neg(e0 + 6); chk("pio4_idle", int'(bus.BUSY), 0);

    // IORDY low from edge 5 for 10 sampled clocks: sync sees 0 for edges 10..17 -> 8 extensions.
    start(1'b1, 1'b0, e0);
    push(e0 + 18, 0, 15, 1, e0 + 17);
    at_neg(e0 + 4);
    @(posedge CLK40); #1;
    bus.IORDY = 1'b0;
    at_neg(e0 + 14);
    @(posedge CLK40); #1;
    bus.IORDY = 1'b1;
    wait_idle();

    // IORDY stuck low, PIO4 read on secondary: 255 extensions then timeout.
    bus.IORDY = 1'b0;
    repeat (3) @(posedge CLK40);
    start(1'b1, 1'b1, e0);
    push(e0 + 259, 1, 258, 1, e0 + 258);
    wait_idle();
    bus.IORDY = 1'b1;
    repeat (3) @(posedge CLK40);

    // Back-to-back: PIO0 write primary, second start (secondary, PIO4 read) in first RECOVER clock.
    start(1'b0, 1'b0, e0);
    push(e0 + 10, 0, 7, 0, -1);
    at_neg(e0 + 10);
    start(1'b1, 1'b1, e1);
    chk("pending_start_edge", e1, e0 + 12);
    bus.SPIO = 1'b0;  // jumper change after capture must not affect the pending cycle
    push(e0 + 28, 0, 3, 1, e0 + 27);
    at_neg(e0 + 23); chk("b2b_recover_cyc_off", int'(bus.ATA_CYC), 0);
    at_neg(e0 + 24); chk("b2b_no_idle_busy", int'(bus.BUSY), 1);
    chk("b2b_setup_cyc_on", int'(bus.ATA_CYC), 1);
    at_neg(e0 + 29); chk("b2b_pio4_busy_last", int'(bus.BUSY), 1);
    at_neg(e0 + 30); chk("b2b_pio4_idle", int'(bus.BUSY), 0);
    bus.SPIO = 1'b1;

    // RESET while in STROBE.
    start(1'b1, 1'b0, e0);
    at_neg(e0 + 4); chk("rst_strobe_active", int'(bus.IORn), 0);
    @(posedge CLK40); #1;
    RESET = 1'b1;
    snap  = tack_total;
    at_neg(e0 + 6);
    chk("rst_iorn", int'(bus.IORn), 1);
    chk("rst_ata_cyc", int'(bus.ATA_CYC), 0);
    chk("rst_busy", int'(bus.BUSY), 0);
    @(posedge CLK40); #1;
    RESET = 1'b0;
    repeat (30) @(negedge CLK40);
    chk("rst_no_tack", tack_total, snap);
    chk("rst_stays_idle", int'(bus.BUSY), 0);

    chk("scoreboard_empty", sbq.size(), 0);
    chk("tack_total", tack_total, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
